decode: RTL

DECODE -- requirements
Module: decode

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/decode_if.sv | 33 +++
 rtl/reg_file.sv | 57 +++++
 rtl/decode.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, R-type funct codes, ALU control
// encodings, CtrlE bit positions and a sign-extension helper.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation select driven into the execute stage
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // CtrlE = {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl[2:0]}
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALU_LSB  = 0;

  // Register file geometry
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;

  // Kind of control transfer the current instruction can request
  typedef enum logic [1:0] {
    BR_NONE,
    BR_EQ,
    BR_NE,
    BR_JUMP
  } br_kind_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Bus between the fetch/writeback/hazard side (master) and the decode
// stage (slave). Signal names follow the pipeline's stage-suffix naming.
interface decode_if;
  import mips_pkg::*;

  // Towards decode
  logic [31:0]       InstrD;
  logic [31:0]       PC_Next;
  logic              RegWriteW;
  logic [REG_AW-1:0] WriteRegW;
  logic [31:0]       ResultW;
  logic              FlushE;

  // From decode
  logic              PC_sel_Mux;
  logic [31:0]       PCT;
  logic [31:0]       RD1E;
  logic [31:0]       RD2E;
  logic [31:0]       ImmE;
  logic [14:0]       RegsE;
  logic [31:0]       PCPlus4E;
  logic [CTRL_W-1:0] CtrlE;

  modport master (
    output InstrD, PC_Next, RegWriteW, WriteRegW, ResultW, FlushE,
    input  PC_sel_Mux, PCT, RD1E, RD2E, ImmE, RegsE, PCPlus4E, CtrlE
  );

  modport slave (
    input  InstrD, PC_Next, RegWriteW, WriteRegW, ResultW, FlushE,
    output PC_sel_Mux, PCT, RD1E, RD2E, ImmE, RegsE, PCPlus4E, CtrlE
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port on the
// rising edge, r0 hard-wired to zero, asynchronous active-low clear.
// Build macro DECODE_WB_BYPASS_EN: a read of the register being written in
// the same cycle returns the incoming write data instead of the old value.
module reg_file
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [31:0]       i_wd,
  output logic [31:0]       o_rd1,
  output logic [31:0]       o_rd2
);

  logic [31:0]       r_regs [REG_NUM];
  logic              w_wr_en;
  logic [REG_AW-1:0] w_ra [2];
  logic [31:0]       w_rd [2];
  logic [1:0]        w_hit;

  // Writes to r0 are dropped so it always reads back as zero
  assign w_wr_en = i_we && (i_wa != '0);

  assign w_ra[0] = i_ra1;
  assign w_ra[1] = i_ra2;
  assign o_rd1   = w_rd[0];
  assign o_rd2   = w_rd[1];

  // Storage: cleared asynchronously, so a same-edge writeback during reset is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef DECODE_WB_BYPASS_EN
      assign w_hit[gi] = w_wr_en && (i_wa == w_ra[gi]);
`else
      assign w_hit[gi] = 1'b0;
`endif
      assign w_rd[gi] = (w_ra[gi] == '0) ? '0 :
                        (w_hit[gi] ? i_wd : r_regs[w_ra[gi]]);
    end
  endgenerate

endmodule

// File: rtl/decode.sv
// MIPS instruction-decode stage: control decode, register read, branch/jump
// resolution (combinational, same cycle as InstrD) and the ID/EX register.
// Build macro DECODE_WB_BYPASS_EN enables writeback-to-read forwarding in
// the register file; branch compares use the same (possibly forwarded) data.
module decode
  import mips_pkg::*;
(
  input logic      clk,
  input logic      rst,
  decode_if.slave  bus
);

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [15:0]       w_imm;
  logic [31:0]       w_imm_ext;
  logic [31:0]       w_rd1;
  logic [31:0]       w_rd2;
  logic [CTRL_W-1:0] w_ctrl;
  br_kind_e          w_br;
  logic              w_pc_sel;
  logic [31:0]       w_pct;

  logic [31:0]       r_rd1e;
  logic [31:0]       r_rd2e;
  logic [31:0]       r_imme;
  logic [14:0]       r_regse;
  logic [31:0]       r_pcplus4e;
  logic [CTRL_W-1:0] r_ctrle;

  assign w_op      = bus.InstrD[31:26];
  assign w_funct   = bus.InstrD[5:0];
  assign w_rs      = bus.InstrD[25:21];
  assign w_rt      = bus.InstrD[20:16];
  assign w_imm     = bus.InstrD[15:0];
  assign w_imm_ext = sext16(w_imm);

  reg_file u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .i_we  (bus.RegWriteW),
    .i_wa  (bus.WriteRegW),
    .i_wd  (bus.ResultW),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Control decode: unsupported opcode/funct falls through to an all-zero NOP
  always_comb begin
    w_ctrl = '0;
    w_br   = BR_NONE;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_REGDST]   = 1'b1;
        case (w_funct)
          FN_ADD:  w_ctrl[CTRL_ALU_LSB +: 3] = ALU_ADD;
          FN_SUB:  w_ctrl[CTRL_ALU_LSB +: 3] = ALU_SUB;
          FN_AND:  w_ctrl[CTRL_ALU_LSB +: 3] = ALU_AND;
          FN_OR:   w_ctrl[CTRL_ALU_LSB +: 3] = ALU_OR;
          FN_SLT:  w_ctrl[CTRL_ALU_LSB +: 3] = ALU_SLT;
          default: w_ctrl = '0;
        endcase
      end
      OP_LW: begin
        w_ctrl[CTRL_REGWRITE]      = 1'b1;
        w_ctrl[CTRL_MEMTOREG]      = 1'b1;
        w_ctrl[CTRL_ALUSRC]        = 1'b1;
        w_ctrl[CTRL_ALU_LSB +: 3]  = ALU_ADD;
      end
      OP_SW: begin
        w_ctrl[CTRL_MEMWRITE]      = 1'b1;
        w_ctrl[CTRL_ALUSRC]        = 1'b1;
        w_ctrl[CTRL_ALU_LSB +: 3]  = ALU_ADD;
      end
      OP_ADDI: begin
        w_ctrl[CTRL_REGWRITE]      = 1'b1;
        w_ctrl[CTRL_ALUSRC]        = 1'b1;
        w_ctrl[CTRL_ALU_LSB +: 3]  = ALU_ADD;
      end
      OP_BEQ: begin
        w_ctrl[CTRL_ALU_LSB +: 3]  = ALU_SUB;
        w_br                       = BR_EQ;
      end
      OP_BNE: begin
        w_ctrl[CTRL_ALU_LSB +: 3]  = ALU_SUB;
        w_br                       = BR_NE;
      end
      OP_J: begin
        w_br = BR_JUMP;
      end
      default: begin
        w_ctrl = '0;
        w_br   = BR_NONE;
      end
    endcase
  end

  // Branch unit: resolve taken/target in the same cycle so fetch can redirect
  always_comb begin
    w_pc_sel = 1'b0;
    w_pct    = bus.PC_Next;
    case (w_br)
      BR_EQ: begin
        if (w_rd1 == w_rd2) begin
          w_pc_sel = 1'b1;
          w_pct    = bus.PC_Next + (w_imm_ext << 2);
        end
      end
      BR_NE: begin
        if (w_rd1 != w_rd2) begin
          w_pc_sel = 1'b1;
          w_pct    = bus.PC_Next + (w_imm_ext << 2);
        end
      end
      BR_JUMP: begin
        w_pc_sel = 1'b1;
        w_pct    = {bus.PC_Next[31:28], bus.InstrD[25:0], 2'b00};
      end
      default: begin
        w_pc_sel = 1'b0;
        w_pct    = bus.PC_Next;
      end
    endcase
  end

  assign bus.PC_sel_Mux = w_pc_sel;
  assign bus.PCT        = w_pct;

  // ID/EX pipeline register: loads every edge, FlushE inserts an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd1e     <= '0;
      r_rd2e     <= '0;
      r_imme     <= '0;
      r_regse    <= '0;
      r_pcplus4e <= '0;
      r_ctrle    <= '0;
    end else if (bus.FlushE) begin
      r_rd1e     <= '0;
      r_rd2e     <= '0;
      r_imme     <= '0;
      r_regse    <= '0;
      r_pcplus4e <= '0;
      r_ctrle    <= '0;
    end else begin
      r_rd1e     <= w_rd1;
      r_rd2e     <= w_rd2;
      r_imme     <= w_imm_ext;
      r_regse    <= bus.InstrD[25:11];
      r_pcplus4e <= bus.PC_Next;
      r_ctrle    <= w_ctrl;
    end
  end

  assign bus.RD1E     = r_rd1e;
  assign bus.RD2E     = r_rd2e;
  assign bus.ImmE     = r_imme;
  assign bus.RegsE    = r_regse;
  assign bus.PCPlus4E = r_pcplus4e;
  assign bus.CtrlE    = r_ctrle;

endmodule
